// File: rtl/imm_decoder.sv
// Instruction immediate decoder. A prefix word may supply the upper 12 bits of
// the next immediate-form instruction. The output stage is a single registered slot.
module imm_decoder #(
    parameter logic [3:0]  PFX_OPCODE = 4'hF,
    parameter logic [15:0] ZEXT_MASK  = 16'h1800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [3:0]  op,
    output logic [15:0] immediate,
    output logic        im_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        pfx_err
);

    typedef enum logic {
        NO_PFX   = 1'b0,
        PFX_HELD = 1'b1
    } state_t;

    state_t      state_q;
    logic [11:0] pfx_q;
    logic        out_valid_q;
    logic [3:0]  op_q;
    logic [15:0] imm_q;
    logic        sel_q;
    logic        err_q;

    logic [3:0]  opc;
    logic        accept;
    logic        is_pfx;
    logic        is_imm;
    logic [15:0] short_imm;
    logic [15:0] imm_d;

    assign opc         = instr[15:12];
    assign instr_ready = !out_valid_q || out_ready;
    assign accept      = instr_valid && instr_ready;
    assign is_pfx      = (opc == PFX_OPCODE);
    // Opcodes above the prefix opcode (only possible with a non-default
    // PFX_OPCODE) fall through to register form.
    assign is_imm      = opc[3] && (opc < PFX_OPCODE);

    always_comb begin
        short_imm = ZEXT_MASK[opc] ? {8'h00, instr[7:0]} : {{8{instr[7]}}, instr[7:0]};
        imm_d     = 16'h0000;
        if (is_imm) begin
            imm_d = (state_q == PFX_HELD) ? {pfx_q, instr[3:0]} : short_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= NO_PFX;
            pfx_q       <= 12'h000;
            out_valid_q <= 1'b0;
            op_q        <= 4'h0;
            imm_q       <= 16'h0000;
            sel_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                case (state_q)
                    NO_PFX: begin
                        if (is_pfx) begin
                            pfx_q   <= instr[11:0];
                            state_q <= PFX_HELD;
                        end else begin
                            out_valid_q <= 1'b1;
                            op_q        <= opc;
                            imm_q       <= imm_d;
                            sel_q       <= is_imm;
                        end
                    end
                    PFX_HELD: begin
                        if (is_pfx) begin
                            // A second prefix replaces the first one.
                            pfx_q <= instr[11:0];
                            err_q <= 1'b1;
                        end else begin
                            out_valid_q <= 1'b1;
                            op_q        <= opc;
                            imm_q       <= imm_d;
                            sel_q       <= is_imm;
                            err_q       <= !is_imm;
                            state_q     <= NO_PFX;
                        end
                    end
                    default: state_q <= NO_PFX;
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign op        = op_q;
    assign immediate = imm_q;
    assign im_sel    = sel_q;
    assign pfx_err   = err_q;

endmodule

// File: tb/tb_imm_decoder.sv
// Self-checking bench for imm_decoder: directed scenarios plus a randomized
// stream checked against a queue-based model of the decoder's contract.
module tb_imm_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  op;
    logic [15:0] immediate;
    logic        im_sel;
    logic        out_valid;
    logic        out_ready;
    logic        pfx_err;

    imm_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op          (op),
        .immediate   (immediate),
        .im_sel      (im_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pfx_err     (pfx_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] imm;
        logic        sel;
    } out_t;

    int   checks = 0;
    int   errors = 0;
    out_t q[$];          // outputs expected to appear, in order
    bit   held;          // model: a prefix is pending
    logic [11:0] hval;
    bit   exp_err;
    bit   exp_ready;
    bit   obs_ready;

    // Drive one cycle of inputs and advance the reference model; no checking here.
    task automatic tick(input bit v, input logic [15:0] w, input bit ordy);
        bit   acc;
        out_t e;
        int   s;
        logic [3:0] opc;
        reset       = 1'b0;
        instr_valid = v;
        instr       = w;
        out_ready   = ordy;
        @(negedge clk);
        obs_ready = instr_ready;
        exp_ready = (q.size() == 0) || ordy;
        acc = v && exp_ready;
        if (q.size() != 0 && ordy) void'(q.pop_front());
        exp_err = 1'b0;
        opc = w[15:12];
        if (acc) begin
            if (opc == 4'hF) begin
                exp_err = held;
                held = 1'b1;
                hval = w[11:0];
            end else begin
                e.op = opc;
                if (opc >= 4'h8) begin
                    e.sel = 1'b1;
                    if (held) e.imm = {hval, w[3:0]};
                    else if (opc == 4'hB || opc == 4'hC) e.imm = {8'h00, w[7:0]};
                    else begin
                        s = w[7] ? int'(w[7:0]) - 256 : int'(w[7:0]);
                        e.imm = 16'(s);
                    end
                end else begin
                    e.sel = 1'b0;
                    e.imm = 16'h0000;
                end
                exp_err = held && (opc < 4'h8);
                held = 1'b0;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick_rst(input bit v, input logic [15:0] w);
        reset       = 1'b1;
        instr_valid = v;
        instr       = w;
        out_ready   = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        held    = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b0; instr = 16'h0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        tick_rst(1'b1, 16'h8123);
        checks++;
        if ({out_valid, op, immediate, im_sel, pfx_err} !== 23'h0)
            $display("FAIL reset_outputs: got %h expected 0", {out_valid, op, immediate, im_sel, pfx_err});
        tick(1'b0, 16'h0, 1'b0);
        checks++;
        if (obs_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", obs_ready);
        if (obs_ready !== 1'b1) errors++;
        if ({out_valid, op, immediate, im_sel, pfx_err} !== 23'h0) errors++;
    endtask

    task automatic test_imm_forms();
        tick(1'b1, 16'h80F5, 1'b1);
        checks++;
        if ({out_valid, op, im_sel, immediate} !== {1'b1, 4'h8, 1'b1, 16'hFFF5}) begin
            errors++;
            $display("FAIL sext_imm: got v=%b op=%h sel=%b imm=%h expected 1 8 1 fff5", out_valid, op, im_sel, immediate);
        end
        tick(1'b1, 16'hB0F5, 1'b1);
        checks++;
        if ({out_valid, op, im_sel, immediate} !== {1'b1, 4'hB, 1'b1, 16'h00F5}) begin
            errors++;
            $display("FAIL zext_imm: got v=%b op=%h sel=%b imm=%h expected 1 b 1 00f5", out_valid, op, im_sel, immediate);
        end
        tick(1'b1, 16'h3123, 1'b1);
        checks++;
        if ({out_valid, op, im_sel, immediate} !== {1'b1, 4'h3, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reg_form: got v=%b op=%h sel=%b imm=%h expected 1 3 0 0000", out_valid, op, im_sel, immediate);
        end
        tick(1'b0, 16'h0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_prefix();
        tick(1'b1, 16'hFABC, 1'b1);
        checks++;
        if ({out_valid, pfx_err} !== 2'b00) begin
            errors++;
            $display("FAIL pfx_no_output: got v=%b err=%b expected 0 0", out_valid, pfx_err);
        end
        tick(1'b1, 16'h9007, 1'b1);
        checks++;
        if ({out_valid, im_sel, immediate, pfx_err} !== {1'b1, 1'b1, 16'hABC7, 1'b0}) begin
            errors++;
            $display("FAIL pfx_combine: got v=%b sel=%b imm=%h err=%b expected 1 1 abc7 0", out_valid, im_sel, immediate, pfx_err);
        end
        tick(1'b1, 16'hF123, 1'b1);
        checks++;
        if ({out_valid, pfx_err} !== 2'b00) begin
            errors++;
            $display("FAIL pfx_drain: got v=%b err=%b expected 0 0", out_valid, pfx_err);
        end
        tick(1'b1, 16'h2000, 1'b1);
        checks++;
        if ({out_valid, op, im_sel, immediate, pfx_err} !== {1'b1, 4'h2, 1'b0, 16'h0, 1'b1}) begin
            errors++;
            $display("FAIL pfx_discard_reg: got v=%b op=%h sel=%b imm=%h err=%b expected 1 2 0 0000 1", out_valid, op, im_sel, immediate, pfx_err);
        end
        tick(1'b1, 16'h8001, 1'b1);
        checks++;
        if ({immediate, pfx_err} !== {16'h0001, 1'b0}) begin
            errors++;
            $display("FAIL after_discard: got imm=%h err=%b expected 0001 0", immediate, pfx_err);
        end
        // A held prefix survives idle cycles.
        tick(1'b1, 16'hF555, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 16'h8FFF, 1'b1);
        tick(1'b1, 16'h8009, 1'b1);
        checks++;
        if (immediate !== 16'h5559) begin
            errors++;
            $display("FAIL pfx_idle_hold: got imm=%h expected 5559", immediate);
        end
        tick(1'b1, 16'hF111, 1'b1);
        tick(1'b1, 16'hF222, 1'b1);
        checks++;
        if ({out_valid, pfx_err} !== 2'b01) begin
            errors++;
            $display("FAIL pfx_overwrite_err: got v=%b err=%b expected 0 1", out_valid, pfx_err);
        end
        tick(1'b1, 16'h8003, 1'b1);
        checks++;
        if ({immediate, pfx_err} !== {16'h2223, 1'b0}) begin
            errors++;
            $display("FAIL pfx_overwrite_val: got imm=%h err=%b expected 2223 0", immediate, pfx_err);
        end
        tick(1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [4];
        logic [15:0] want  [4];
        bit          sched [10];
        logic [15:0] got[$];
        logic [15:0] stalled_imm;
        int idx = 0;
        words = '{16'h8011, 16'h8122, 16'h8233, 16'h8344};
        want  = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        sched = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
        stalled_imm = 16'h0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && sched[c]) got.push_back(immediate);
            if (!sched[c]) stalled_imm = immediate;
            tick(idx < 4, words[idx % 4], sched[c]);
            if (obs_ready && idx < 4) idx++;
            if (!sched[c]) begin
                checks++;
                if (obs_ready !== 1'b0 || immediate !== stalled_imm) begin
                    errors++;
                    $display("FAIL stall_c%0d: got ready=%b imm=%h expected 0 %h", c, obs_ready, immediate, stalled_imm);
                end
            end
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL stream_count: got %0d expected 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== want[i]) begin
                    errors++;
                    $display("FAIL stream_order_%0d: got %h expected %h", i, got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 16'h8055, 1'b1);
        tick_rst(1'b1, 16'h8066);
        checks++;
        if ({out_valid, op, immediate, im_sel, pfx_err} !== 23'h0) begin
            errors++;
            $display("FAIL reset_pending_out: got %h expected 0", {out_valid, op, immediate, im_sel, pfx_err});
        end
        tick(1'b1, 16'hF777, 1'b1);
        tick_rst(1'b1, 16'h8066);
        checks++;
        if ({out_valid, op, immediate, im_sel, pfx_err} !== 23'h0) begin
            errors++;
            $display("FAIL reset_held_pfx: got %h expected 0", {out_valid, op, immediate, im_sel, pfx_err});
        end
        tick(1'b1, 16'h8002, 1'b1);
        checks++;
        if ({out_valid, immediate, pfx_err} !== {1'b1, 16'h0002, 1'b0}) begin
            errors++;
            $display("FAIL pfx_gone: got v=%b imm=%h err=%b expected 1 0002 0", out_valid, immediate, pfx_err);
        end
    endtask

    task automatic test_random();
        logic [3:0]  opc;
        logic [15:0] w;
        for (int c = 0; c < 400; c++) begin
            opc = ($urandom_range(0, 9) < 3) ? 4'hF : 4'($urandom_range(0, 14));
            w = {opc, 12'($urandom)};
            tick($urandom_range(0, 3) != 0, w, $urandom_range(0, 9) < 7);
            checks++;
            if (obs_ready !== exp_ready) begin
                errors++;
                $display("FAIL rnd_ready_c%0d: got %b expected %b", c, obs_ready, exp_ready);
            end
            checks++;
            if (out_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rnd_valid_c%0d: got %b expected %b", c, out_valid, q.size() != 0);
            end
            checks++;
            if (pfx_err !== exp_err) begin
                errors++;
                $display("FAIL rnd_err_c%0d: got %b expected %b", c, pfx_err, exp_err);
            end
            if (q.size() != 0) begin
                checks++;
                if ({op, immediate, im_sel} !== q[0]) begin
                    errors++;
                    $display("FAIL rnd_data_c%0d: got op=%h imm=%h sel=%b expected op=%h imm=%h sel=%b",
                             c, op, immediate, im_sel, q[0].op, q[0].imm, q[0].sel);
                end
            end
        end
    endtask

    initial begin
        held = 1'b0;
        hval = 12'h0;
        test_reset();
        test_imm_forms();
        test_prefix();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
